led_frame_scheduler: RTL and testbench

- Double-buffered 8x8 frame store between the snake game logic and the 8x8 LED matrix scan driver.
- Game logic draws pixels into a back buffer through a valid/ready port and can clear the back buffer or commit it.
- A commit swaps front and back buffers exactly at a scan-frame boundary, so the matrix never shows a half-drawn frame; after the swap the new front is copied into the back buffer for incremental drawing.
- Drives row1..row8 of the scan driver.

---
 rtl/led_frame_scheduler.sv | 162 ++++++++++++++++
 tb/tb_led_frame_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler: double-buffered 8x8 frame store between the snake game
// logic and the LED matrix scan driver. Game logic draws into the back buffer;
// a commit swaps buffers on a scan-frame boundary, then the new front is copied
// into the back buffer so drawing can continue incrementally.
// Optional build macro: LED_TEST_PATTERN_EN adds a test_mode input that
// replaces the row outputs with an inverting checkerboard.
module led_frame_scheduler #(
  parameter int SCAN_CYCLES = 72
) (
  input  logic       clk,
  input  logic       reset,
`ifdef LED_TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_x,
  input  logic [2:0] wr_y,
  input  logic       wr_data,
  input  logic       clr_req,
  input  logic       commit,
  output logic       busy,
  output logic       frame_tick,
  output logic [7:0] swap_count,
  output logic [7:0] row1,
  output logic [7:0] row2,
  output logic [7:0] row3,
  output logic [7:0] row4,
  output logic [7:0] row5,
  output logic [7:0] row6,
  output logic [7:0] row7,
  output logic [7:0] row8
);

  localparam logic [7:0] LAST_CNT = 8'(SCAN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, WAIT, COPY} state_t;

  state_t                 state, state_next;
  logic [2:0]             row_idx, row_idx_next;
  logic [7:0]             cnt;
  logic                   front_sel;
  logic                   back_sel;
  logic [1:0][7:0][7:0]   mem;
  logic [7:0][7:0]        row_q;
  logic [7:0][7:0]        row_next;
  logic [7:0]             swaps;
  logic                   wr_fire;
  logic                   swap_now;

  assign back_sel   = ~front_sel;
  assign frame_tick = (cnt == LAST_CNT);
  assign wr_ready   = reset && (state == IDLE) && !clr_req;
  assign wr_fire    = wr_valid && wr_ready;
  assign swap_now   = (state == WAIT) && frame_tick;
  assign busy       = (state != IDLE);
  assign swap_count = swaps;

  assign row1 = row_q[0];
  assign row2 = row_q[1];
  assign row3 = row_q[2];
  assign row4 = row_q[3];
  assign row5 = row_q[4];
  assign row6 = row_q[5];
  assign row7 = row_q[6];
  assign row8 = row_q[7];

  // Free-running scan frame counter, aligned with the scan driver after reset.
  always_ff @(posedge clk) begin
    if (!reset) cnt <= '0;
    else if (frame_tick) cnt <= '0;
    else cnt <= cnt + 8'd1;
  end

  // State and row index registers; reset drops any pending commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      row_idx <= '0;
    end else begin
      state   <= state_next;
      row_idx <= row_idx_next;
    end
  end

  // Next-state logic: commit beats clear, busy states ignore requests.
  always_comb begin
    state_next   = state;
    row_idx_next = row_idx;
    case (state)
      IDLE: begin
        row_idx_next = '0;
        if (commit) state_next = WAIT;
        else if (clr_req) state_next = CLEAR;
      end
      CLEAR, COPY: begin
        row_idx_next = row_idx + 3'd1;
        if (row_idx == 3'd7) state_next = IDLE;
      end
      WAIT: begin
        if (frame_tick) begin
          state_next   = COPY;
          row_idx_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame buffers: pixel writes, row clearing, swap and post-swap copy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem       <= '0;
      front_sel <= 1'b0;
    end else begin
      if (wr_fire) mem[back_sel][wr_y][3'd7 - wr_x] <= wr_data;
      case (state)
        CLEAR:   mem[back_sel][row_idx] <= '0;
        WAIT:    if (frame_tick) front_sel <= ~front_sel;
        COPY:    mem[back_sel][row_idx] <= mem[front_sel][row_idx];
        default: ;
      endcase
    end
  end

  // Completed swap counter, wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (!reset) swaps <= '0;
    else if (swap_now) swaps <= swaps + 8'd1;
  end

`ifdef LED_TEST_PATTERN_EN
  logic pat_phase;
  logic pat_next;

  assign pat_next = pat_phase ^ frame_tick;

  // Checkerboard phase, inverted on every frame boundary.
  always_ff @(posedge clk) begin
    if (!reset) pat_phase <= 1'b0;
    else pat_phase <= pat_next;
  end
`endif

  // Row source: on the swap edge take the outgoing back buffer so the new frame shows at cnt 0.
  always_comb begin
    row_next = '0;
    for (int i = 0; i < 8; i++) begin
      row_next[i] = swap_now ? mem[back_sel][i] : mem[front_sel][i];
`ifdef LED_TEST_PATTERN_EN
      if (test_mode) row_next[i] = (pat_next ^ i[0]) ? 8'h55 : 8'hAA;
`endif
    end
  end

  // Registered row outputs to the scan driver.
  always_ff @(posedge clk) begin
    if (!reset) row_q <= '0;
    else row_q <= row_next;
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// tb_led_frame_scheduler: table-driven bench for led_frame_scheduler with a
// frame-counter model checked every clock, plus hand sequences for commit on
// a frame_tick cycle and reset during WAIT.
module tb_led_frame_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_x = '0;
  logic [2:0] wr_y = '0;
  logic       wr_data = 1'b0;
  logic       clr_req = 1'b0;
  logic       commit = 1'b0;
  logic       busy;
  logic       frame_tick;
  logic [7:0] swap_count;
  logic [7:0] row1, row2, row3, row4, row5, row6, row7, row8;
`ifdef LED_TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int mcnt = 0;
  int last_swap_steps = 0;
  logic [63:0] front_m = '0;

  typedef struct {
    logic        wv;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        d;
    logic        clr;
    logic        cmt;
    logic        exp_ready;
    logic [63:0] exp_rows;
    logic [7:0]  exp_swaps;
  } vec_t;

  vec_t vecs [12];

  led_frame_scheduler #(.SCAN_CYCLES(72)) dut (
    .clk(clk),
    .reset(reset),
`ifdef LED_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_x(wr_x),
    .wr_y(wr_y),
    .wr_data(wr_data),
    .clr_req(clr_req),
    .commit(commit),
    .busy(busy),
    .frame_tick(frame_tick),
    .swap_count(swap_count),
    .row1(row1),
    .row2(row2),
    .row3(row3),
    .row4(row4),
    .row5(row5),
    .row6(row6),
    .row7(row7),
    .row8(row8)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case something hangs
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(logic wv, logic [2:0] x, logic [2:0] y, logic d,
                              logic clr, logic cmt, logic exp_ready,
                              logic [63:0] exp_rows, logic [7:0] exp_swaps);
    vec_t v;
    v.wv = wv; v.x = x; v.y = y; v.d = d; v.clr = clr; v.cmt = cmt;
    v.exp_ready = exp_ready; v.exp_rows = exp_rows; v.exp_swaps = exp_swaps;
    return v;
  endfunction

  function automatic logic [63:0] pack_rows();
    return {row1, row2, row3, row4, row5, row6, row7, row8};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock: advance the frame counter model and check frame_tick against it.
  task automatic stepCycle();
    logic r;
    @(posedge clk);
    r = reset;
    #1;
    if (!r) mcnt = 0;
    else mcnt = (mcnt == 71) ? 0 : mcnt + 1;
    checkOutput("frame_tick", {63'd0, frame_tick}, {63'd0, mcnt == 71});
  endtask

  // Apply one vector; commits and clears are followed through to IDLE.
  task automatic applyStimulus(input vec_t v);
    bit done;
    wr_valid = v.wv; wr_x = v.x; wr_y = v.y; wr_data = v.d;
    clr_req = v.clr; commit = v.cmt;
    #1;
    checkOutput("wr_ready", {63'd0, wr_ready}, {63'd0, v.exp_ready});
    stepCycle();
    wr_valid = 1'b0; clr_req = 1'b0; commit = 1'b0;
    last_swap_steps = 0;
    if (v.cmt) begin
      checkOutput("busy_wait", {63'd0, busy}, 64'd1);
      #1;
      checkOutput("ready_busy", {63'd0, wr_ready}, 64'd0);
      done = 1'b0;
      for (int i = 0; i < 80 && !done; i++) begin
        checkOutput("rows_hold", pack_rows(), front_m);
        stepCycle();
        last_swap_steps++;
        if (mcnt == 0) done = 1'b1;
      end
      checkOutput("rows_swap", pack_rows(), v.exp_rows);
      checkOutput("swap_count_swap", {56'd0, swap_count}, {56'd0, v.exp_swaps});
      checkOutput("busy_copy0", {63'd0, busy}, 64'd1);
      for (int k = 1; k <= 8; k++) begin
        stepCycle();
        checkOutput("busy_copy", {63'd0, busy}, {63'd0, k < 8});
      end
    end else if (v.clr) begin
      checkOutput("busy_clear0", {63'd0, busy}, 64'd1);
      for (int k = 1; k <= 8; k++) begin
        stepCycle();
        checkOutput("busy_clear", {63'd0, busy}, {63'd0, k < 8});
      end
    end else begin
      checkOutput("busy_idle", {63'd0, busy}, 64'd0);
    end
    front_m = v.exp_rows;
    checkOutput("rows", pack_rows(), v.exp_rows);
    checkOutput("swap_count", {56'd0, swap_count}, {56'd0, v.exp_swaps});
  endtask

  initial begin
    int ticks;

    vecs[0]  = mk(1, 3'd0, 3'd0, 1, 0, 0, 1, 64'h0000_0000_0000_0000, 8'd0);
    vecs[1]  = mk(1, 3'd7, 3'd7, 1, 0, 0, 1, 64'h0000_0000_0000_0000, 8'd0);
    vecs[2]  = mk(0, 3'd0, 3'd0, 0, 0, 1, 1, 64'h8000_0000_0000_0001, 8'd1);
    vecs[3]  = mk(1, 3'd3, 3'd2, 1, 0, 0, 1, 64'h8000_0000_0000_0001, 8'd1);
    vecs[4]  = mk(0, 3'd0, 3'd0, 0, 0, 1, 1, 64'h8000_1000_0000_0001, 8'd2);
    vecs[5]  = mk(1, 3'd5, 3'd5, 1, 1, 0, 0, 64'h8000_1000_0000_0001, 8'd2);
    vecs[6]  = mk(0, 3'd0, 3'd0, 0, 0, 1, 1, 64'h0000_0000_0000_0000, 8'd3);
    vecs[7]  = mk(1, 3'd1, 3'd4, 1, 0, 1, 1, 64'h0000_0000_4000_0000, 8'd4);
    vecs[8]  = mk(1, 3'd6, 3'd0, 1, 0, 0, 1, 64'h0000_0000_4000_0000, 8'd4);
    vecs[9]  = mk(0, 3'd0, 3'd0, 0, 1, 1, 0, 64'h0200_0000_4000_0000, 8'd5);
    vecs[10] = mk(1, 3'd1, 3'd4, 0, 0, 0, 1, 64'h0200_0000_4000_0000, 8'd5);
    vecs[11] = mk(0, 3'd0, 3'd0, 0, 0, 1, 1, 64'h0200_0000_0000_0000, 8'd6);

    $display("[TB] reset");
    repeat (3) stepCycle();
    checkOutput("rst_rows", pack_rows(), 64'd0);
    checkOutput("rst_swap_count", {56'd0, swap_count}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    reset = 1'b1;
    mcnt = 0;

    $display("[TB] idle after reset");
    ticks = 0;
    for (int i = 0; i < 150; i++) begin
      stepCycle();
      if (frame_tick) ticks++;
    end
    checkOutput("idle_tick_count", ticks, 64'd2);
    checkOutput("idle_rows", pack_rows(), 64'd0);
    checkOutput("idle_swap_count", {56'd0, swap_count}, 64'd0);
    checkOutput("idle_wr_ready", {63'd0, wr_ready}, 64'd1);

    $display("[TB] vector table");
    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    $display("[TB] commit on frame_tick cycle");
    applyStimulus(mk(1, 3'd0, 3'd7, 1, 0, 0, 1, 64'h0200_0000_0000_0000, 8'd6));
    for (int i = 0; i < 80 && mcnt != 71; i++) stepCycle();
    checkOutput("tick_before_commit", {63'd0, frame_tick}, 64'd1);
    applyStimulus(mk(0, 3'd0, 3'd0, 0, 0, 1, 1, 64'h0200_0000_0000_0080, 8'd7));
    checkOutput("commit_on_tick_latency", last_swap_steps, 64'd72);

    $display("[TB] reset during WAIT");
    for (int i = 0; i < 80 && mcnt != 10; i++) stepCycle();
    wr_valid = 1'b1; wr_x = 3'd4; wr_y = 3'd4; wr_data = 1'b1; commit = 1'b1;
    stepCycle();
    wr_valid = 1'b0; commit = 1'b0;
    repeat (5) stepCycle();
    checkOutput("wait_busy", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    repeat (2) stepCycle();
    checkOutput("midwait_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("midwait_rst_swap_count", {56'd0, swap_count}, 64'd0);
    checkOutput("midwait_rst_rows", pack_rows(), 64'd0);
    checkOutput("midwait_rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    reset = 1'b1;
    repeat (100) stepCycle();
    checkOutput("post_rst_swap_count", {56'd0, swap_count}, 64'd0);
    checkOutput("post_rst_rows", pack_rows(), 64'd0);
    checkOutput("post_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("post_rst_wr_ready", {63'd0, wr_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
